// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetches from a 16-word instruction memory and
// drives register-file/ALU controls for add/sub until halt, illegal word or end of memory.
module instr_sequencer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        abort_i,
    output logic [3:0]  inst_addr_o,
    input  logic [31:0] inst_data_i,
    output logic [4:0]  rf_a1_o,
    output logic [4:0]  rf_a2_o,
    output logic [4:0]  rf_a3_o,
    output logic        rf_we_o,
    output logic [2:0]  alu_ctrl_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [4:0]  instr_count_o
);

    localparam int unsigned AW  = 4;
    localparam int unsigned DW  = 32;
    localparam int unsigned RW  = 5;
    localparam int unsigned OPW = 3;
    localparam int unsigned CW  = 5;

    localparam logic [1:0]     CLASS_ALU = 2'b10;
    localparam logic [OPW-1:0] OP_ADD    = 3'b010;
    localparam logic [OPW-1:0] OP_SUB    = 3'b110;
    localparam logic [AW-1:0]  PC_LAST   = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    state_e         state_q, state_d;
    logic [AW-1:0]  pc_q, pc_d;
    logic [DW-1:0]  ir_q, ir_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           err_q, err_d;

    logic [RW-1:0]  rf_a1_q, rf_a1_d;
    logic [RW-1:0]  rf_a2_q, rf_a2_d;
    logic [RW-1:0]  rf_a3_q, rf_a3_d;
    logic           rf_we_q, rf_we_d;
    logic [OPW-1:0] alu_ctrl_q, alu_ctrl_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           ir_legal;

    assign ir_legal = (ir_q[31:30] == CLASS_ALU) &&
                      ((ir_q[29:27] == OP_ADD) || (ir_q[29:27] == OP_SUB));

    // Next-state logic; abort overrides every non-IDLE transition and freezes pc/count/err
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        if ((state_q != S_IDLE) && abort_i) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        pc_d    = '0;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: begin
                    ir_d    = inst_data_i;
                    state_d = S_DECODE;
                end
                S_DECODE: begin
                    if (ir_q == '0) begin
                        state_d = S_DONE;
                    end else if (!ir_legal) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: state_d = S_WB;
                S_WB: begin
                    cnt_d = CW'(cnt_q + CW'(1));
                    if (pc_q == PC_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        pc_d    = AW'(pc_q + AW'(1));
                        state_d = S_FETCH;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output decode from the upcoming state so the registered outputs track the state they describe
    always_comb begin
        rf_a1_d    = '0;
        rf_a2_d    = '0;
        rf_a3_d    = '0;
        alu_ctrl_d = '0;
        rf_we_d    = 1'b0;
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);

        if ((state_d == S_DECODE) || (state_d == S_EXEC) || (state_d == S_WB)) begin
            rf_a1_d = ir_d[25:21];
            rf_a2_d = ir_d[20:16];
            rf_a3_d = ir_d[15:11];
        end
        if ((state_d == S_EXEC) || (state_d == S_WB)) begin
            alu_ctrl_d = ir_d[29:27];
        end
        if (state_d == S_WB) begin
            rf_we_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            rf_a1_q    <= '0;
            rf_a2_q    <= '0;
            rf_a3_q    <= '0;
            rf_we_q    <= 1'b0;
            alu_ctrl_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            rf_a1_q    <= rf_a1_d;
            rf_a2_q    <= rf_a2_d;
            rf_a3_q    <= rf_a3_d;
            rf_we_q    <= rf_we_d;
            alu_ctrl_q <= alu_ctrl_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign inst_addr_o   = pc_q;
    assign rf_a1_o       = rf_a1_q;
    assign rf_a2_o       = rf_a2_q;
    assign rf_a3_o       = rf_a3_q;
    assign rf_we_o       = rf_we_q;
    assign alu_ctrl_o    = alu_ctrl_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign instr_count_o = cnt_q;

endmodule
